// File: rtl/dmi_reg_bridge.sv
// DMI register bridge: queues debug register requests, routes each one to a target
// selected by the upper address bits, and returns read data or a timeout status.
module dmi_reg_bridge #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int N_TGT   = 2,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      io_core_clk,
  input  logic                      io_core_rst_n,
  input  logic                      io_dmi_hard_reset,
  input  logic                      io_req_valid,
  output logic                      io_req_ready,
  input  logic                      io_req_wr_en,
  input  logic [ADDR_W-1:0]         io_req_addr,
  input  logic [DATA_W-1:0]         io_req_wr_data,
  output logic                      io_resp_valid,
  input  logic                      io_resp_ready,
  output logic [DATA_W-1:0]         io_resp_data,
  output logic [1:0]                io_resp_status,
  output logic [N_TGT-1:0]          io_tgt_en,
  output logic                      io_tgt_wr_en,
  output logic [ADDR_W-$clog2(N_TGT)-1:0] io_tgt_addr,
  output logic [DATA_W-1:0]         io_tgt_wr_data,
  input  logic [N_TGT*DATA_W-1:0]   io_tgt_rd_data,
  input  logic [N_TGT-1:0]          io_tgt_ack,
  output logic                      io_busy
);

  localparam int TS = $clog2(N_TGT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int TA = ADDR_W - TS;
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  state_t            r_state;
  logic [CW-1:0]     r_timer;
  logic              r_wr_en;
  logic [TS-1:0]     r_sel;
  logic [N_TGT-1:0]  r_tgt_en;
  logic              r_tgt_wr_en;
  logic [TA-1:0]     r_tgt_addr;
  logic [DATA_W-1:0] r_tgt_wr_data;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic [1:0]        r_resp_status;

  logic              w_flush;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_head_wr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] w_rd_slice [N_TGT];

  assign w_flush = ~io_core_rst_n | io_dmi_hard_reset;
  assign w_ready = io_core_rst_n & ~io_dmi_hard_reset & (r_count < FULL);
  assign w_push  = io_req_valid & w_ready;
  // The in-flight request stays in the FIFO until its response is taken.
  assign w_pop   = (r_state == S_RESP) & io_resp_ready;
  assign {w_head_wr, w_head_addr, w_head_data} = r_mem[r_rptr];

  for (genvar g = 0; g < N_TGT; g++) begin : g_slice
    assign w_rd_slice[g] = io_tgt_rd_data[g*DATA_W +: DATA_W];
  end

  always_ff @(posedge io_core_clk) begin
    if (w_push) r_mem[r_wptr] <= {io_req_wr_en, io_req_addr, io_req_wr_data};
  end

  always_ff @(posedge io_core_clk) begin
    if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge io_core_clk) begin
    if (w_flush) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_wr_en       <= 1'b0;
      r_sel         <= '0;
      r_tgt_en      <= '0;
      r_tgt_wr_en   <= 1'b0;
      r_tgt_addr    <= '0;
      r_tgt_wr_data <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_status <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_wr_en       <= w_head_wr;
            r_sel         <= w_head_addr[ADDR_W-1 -: TS];
            r_tgt_en      <= N_TGT'(1) << w_head_addr[ADDR_W-1 -: TS];
            r_tgt_wr_en   <= w_head_wr;
            r_tgt_addr    <= w_head_addr[TA-1:0];
            r_tgt_wr_data <= w_head_data;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tgt_en      <= '0;
          r_tgt_wr_en   <= 1'b0;
          r_tgt_addr    <= '0;
          r_tgt_wr_data <= '0;
          r_timer       <= '0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          // Only the selected target's ack counts; others are ignored.
          if (io_tgt_ack[r_sel]) begin
            r_resp_data   <= r_wr_en ? '0 : w_rd_slice[r_sel];
            r_resp_status <= 2'd0;
            r_resp_valid  <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_timer == LAST) begin
            r_resp_data   <= '0;
            r_resp_status <= 2'd3;
            r_resp_valid  <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (io_resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_status <= 2'd0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign io_req_ready   = w_ready;
  assign io_resp_valid  = r_resp_valid & io_core_rst_n;
  assign io_resp_data   = r_resp_data & {DATA_W{io_core_rst_n}};
  assign io_resp_status = r_resp_status & {2{io_core_rst_n}};
  assign io_tgt_en      = r_tgt_en & {N_TGT{io_core_rst_n}};
  assign io_tgt_wr_en   = r_tgt_wr_en & io_core_rst_n;
  assign io_tgt_addr    = r_tgt_addr & {TA{io_core_rst_n}};
  assign io_tgt_wr_data = r_tgt_wr_data & {DATA_W{io_core_rst_n}};
  assign io_busy        = io_core_rst_n & ((r_count != '0) | (r_state != S_IDLE));

endmodule

// File: doc/dmi_reg_bridge.md
DMI_REG_BRIDGE -- requirements
Module: dmi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: DMI register address width.
REQ-002 SHALL have parameter DATA_W, default 32: register data width.
REQ-003 SHALL have parameter N_TGT, default 2: number of register targets, power of 2, at least 2; TS = log2(N_TGT).
REQ-004 SHALL have parameter DEPTH, default 2: request FIFO depth, power of 2, at least 2.
REQ-005 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles, at least 1.
REQ-006 SHALL have port io_core_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port io_core_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port io_dmi_hard_reset, input, 1 bit: synchronous flush request.
REQ-009 SHALL have ports io_req_valid (input, 1), io_req_ready (output, 1), io_req_wr_en (input, 1), io_req_addr (input, ADDR_W) and io_req_wr_data (input, DATA_W): the request channel.
REQ-010 SHALL have ports io_resp_valid (output, 1), io_resp_ready (input, 1), io_resp_data (output, DATA_W) and io_resp_status (output, 2): the response channel.
REQ-011 SHALL have ports io_tgt_en (output, N_TGT, one-hot), io_tgt_wr_en (output, 1), io_tgt_addr (output, ADDR_W-TS) and io_tgt_wr_data (output, DATA_W): the target request bus.
REQ-012 SHALL have ports io_tgt_rd_data (input, N_TGT*DATA_W; target i occupies slice i) and io_tgt_ack (input, N_TGT): the target return bus.
REQ-013 SHALL have port io_busy (output, 1): high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-014 SHALL accept a request on the cycle io_req_valid and io_req_ready are both high, pushing {wr_en, addr, wr_data} into the FIFO.
REQ-015 SHALL drive io_req_ready = (count < DEPTH) and not io_dmi_hard_reset, with no pop-bypass, so a full FIFO stalls even while a pop occurs.
REQ-016 SHALL process simultaneous push and pop in the same cycle, leaving count unchanged; pointers wrap modulo DEPTH.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if count > 0, SHALL go to ISSUE, latching the FIFO head; sel = addr[ADDR_W-1 -: TS].
REQ-019 ISSUE: SHALL hold io_tgt_en[sel] high for exactly one cycle, drive io_tgt_wr_en/io_tgt_addr (addr[ADDR_W-TS-1:0])/io_tgt_wr_data from the latched request, clear the timeout counter, and go to WAIT.
REQ-020 WAIT: SHALL sample io_tgt_ack[sel] only; on ack, go to RESP with data = rd_data slice sel (0 for writes) and status 0.
REQ-021 WAIT: acks from unselected targets, and any ack during ISSUE, SHALL be ignored.
REQ-022 WAIT: if the counter equals TIMEOUT-1 with no ack, SHALL go to RESP with data 0 and status 3; WAIT lasts at most TIMEOUT cycles.
REQ-023 RESP: io_resp_valid SHALL be high and io_resp_data/io_resp_status stable until io_resp_ready; on the handshake, SHALL pop the FIFO and go to IDLE.
REQ-024 SHALL have a latency, from request accept at cycle 0 into an empty FIFO in IDLE, of: ISSUE at cycle 2; ack at cycle 3 gives io_resp_valid at cycle 4.
REQ-025 io_dmi_hard_reset high SHALL, next cycle, empty the FIFO, force IDLE, deassert io_resp_valid and io_tgt_en, and discard any in-flight transaction or pending response; it takes priority over push, pop and acks.
REQ-026 io_tgt_wr_en, io_tgt_addr and io_tgt_wr_data SHALL be 0 outside ISSUE.

Reset
REQ-027 io_core_rst_n low at a clock edge SHALL clear the FIFO pointers and count, set the FSM to IDLE, and clear the counter and latched request.
REQ-028 While io_core_rst_n is low, all outputs SHALL be 0, including io_req_ready.
REQ-029 Reset asserted mid-transaction SHALL abandon it without a response; late acks after reset SHALL be ignored.

Verification
REQ-030 Read: read addr 0x45 with N_TGT=2 (sel=1, tgt_addr 0x05); target 1 acks at cycle 3 with 0xDEADBEEF -> io_tgt_en=2'b10 at cycle 2; resp_valid at cycle 4 with data 0xDEADBEEF, status 0.
REQ-031 Timeout: write to sel 0, never ack, TIMEOUT=15 -> resp status 3, data 0, exactly 15 WAIT cycles after ISSUE; target 1 acking during WAIT has no effect.
REQ-032 Backpressure: DEPTH=2, resp_ready held low, 4 requests offered -> 2 accepted, req_ready low; releasing resp_ready drains them in order, then accepts the rest.
REQ-033 Hard reset: hard_reset pulsed during WAIT with 1 queued entry -> next cycle FSM in IDLE, count 0, busy 0, no resp_valid; a later ack is ignored.
REQ-034 Reset: rst_n low for 1 cycle while in RESP -> resp_valid 0 and all outputs 0 during reset; afterwards req_ready 1 and busy 0.
REQ-035 Simultaneous push/pop: full FIFO with resp handshake and req_valid in the same cycle -> request not accepted (req_ready 0); next cycle it is accepted, count returns to DEPTH.
